// File: rtl/stream_agg_pkg.sv
// Shared constants for the CHDR stream aggregator: header field offsets,
// default UDP ports / SID, and the data-input port helper.
package stream_agg_pkg;

    localparam int HDR_FLAG_BIT = 63;
    localparam int SID_LSB      = 16;
    localparam int SID_W        = 16;

    localparam logic [15:0] DEF_FC_SID    = 16'h0050;
    localparam int          DEF_CTRL_PORT = 49200;
    localparam int          DEF_FC_PORT   = 49202;
    localparam int          DEF_DATA_BASE = 49202;
    localparam int          DEF_DATA_STEP = 2;

    typedef enum logic {
        ST_IDLE,
        ST_PASS
    } agg_state_t;

    // Caller truncates to the UDP port width, which gives the mod 2^USER_W wrap.
    function automatic int data_port(input int base, input int step, input int idx);
        return base + step * idx;
    endfunction

endpackage

// File: rtl/stream_agg_arb.sv
// Grant selection: lowest-index priority requester first, otherwise the first
// non-priority requester after the round-robin pointer, searching upward with wrap.
module stream_agg_arb #(
    parameter int NUM_IN = 3,
    parameter int IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [NUM_IN-1:0] prio_mask,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_valid
);

    logic [NUM_IN-1:0] prio_req;
    logic [NUM_IN-1:0] norm_req;

    // Loops run from lowest to highest preference so the last hit wins.
    always_comb begin
        int idx;
        prio_req    = req & prio_mask;
        norm_req    = req & ~prio_mask;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        if (|prio_req) begin
            grant_valid = 1'b1;
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (prio_req[i]) begin
                    grant_idx = IDX_W'(i);
                end
            end
        end else begin
            grant_valid = |norm_req;
            for (int k = NUM_IN; k >= 1; k--) begin
                idx = (int'(rr_ptr) + k) % NUM_IN;
                if (norm_req[idx]) begin
                    grant_idx = IDX_W'(idx);
                end
            end
        end
        grant = grant_valid ? (NUM_IN'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/stream_aggregation_n.sv
// N-input packet-atomic CHDR aggregator: per-packet arbitration, UDP port
// classification on the first beat, per-input packet counters.
module stream_aggregation_n
    import stream_agg_pkg::*;
#(
    parameter int                CHDR_W       = 64,
    parameter int                USER_W       = 16,
    parameter int                NUM_IN       = 3,
    parameter logic [NUM_IN-1:0] RESP_MASK    = NUM_IN'(1),
    parameter logic [NUM_IN-1:0] PRIO_MASK    = NUM_IN'(1),
    parameter logic [15:0]       FC_SID       = DEF_FC_SID,
    parameter int                CTRL_PORT    = DEF_CTRL_PORT,
    parameter int                FC_PORT      = DEF_FC_PORT,
    parameter int                DATA_BASE    = DEF_DATA_BASE,
    parameter int                DATA_STEP    = DEF_DATA_STEP,
    parameter int                IN_FIFO_SIZE = 0,
    parameter int                OUT_REG      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [NUM_IN*CHDR_W-1:0] i_tdata,
    input  logic [NUM_IN-1:0]        i_tlast,
    input  logic [NUM_IN-1:0]        i_tvalid,
    output logic [NUM_IN-1:0]        i_tready,
    output logic [CHDR_W-1:0]        o_tdata,
    output logic [USER_W-1:0]        o_tuser,
    output logic                     o_tlast,
    output logic                     o_tvalid,
    input  logic                     o_tready,
    output logic [NUM_IN*16-1:0]     stat_pkts,
    output logic                     err_nohdr
);

    localparam int IDX_W = $clog2(NUM_IN);
    localparam int PAY_W = USER_W + 1 + CHDR_W;

    logic [CHDR_W-1:0] in_data [NUM_IN];
    logic [NUM_IN-1:0] in_last;
    logic [NUM_IN-1:0] in_valid;
    logic [NUM_IN-1:0] in_ready;

    agg_state_t        state, state_nxt;
    logic [IDX_W-1:0]  grant_idx_r;
    logic [USER_W-1:0] port_r;
    logic [IDX_W-1:0]  rr_ptr;
    logic [15:0]       stat_cnt [NUM_IN];

    logic [NUM_IN-1:0] arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic [USER_W-1:0] port_sel;
    logic              nohdr_sel;

    logic [CHDR_W-1:0] core_data;
    logic [USER_W-1:0] core_user;
    logic              core_last;
    logic              core_valid;
    logic              core_ready;
    logic              pkt_done;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        if (IN_FIFO_SIZE == 0) begin : g_bypass
            assign in_data[i]  = i_tdata[i*CHDR_W +: CHDR_W];
            assign in_last[i]  = i_tlast[i];
            assign in_valid[i] = i_tvalid[i];
            assign i_tready[i] = in_ready[i];
        end else begin : g_fifo
            localparam int DEPTH = 2 ** IN_FIFO_SIZE;
            logic [CHDR_W:0]       mem [DEPTH];
            logic [IN_FIFO_SIZE:0] wr_ptr, rd_ptr, fill;
            logic                  full;

            assign fill        = wr_ptr - rd_ptr;
            assign full        = fill[IN_FIFO_SIZE];
            assign i_tready[i] = !full;
            assign in_valid[i] = (wr_ptr != rd_ptr);
            assign in_data[i]  = mem[rd_ptr[IN_FIFO_SIZE-1:0]][CHDR_W-1:0];
            assign in_last[i]  = mem[rd_ptr[IN_FIFO_SIZE-1:0]][CHDR_W];

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (i_tvalid[i] && !full) begin
                        mem[wr_ptr[IN_FIFO_SIZE-1:0]] <= {i_tlast[i], i_tdata[i*CHDR_W +: CHDR_W]};
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (in_valid[i] && in_ready[i]) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
            end
        end
        assign stat_pkts[i*16 +: 16] = stat_cnt[i];
    end

    stream_agg_arb #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req         (in_valid),
        .prio_mask   (PRIO_MASK),
        .rr_ptr      (rr_ptr),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Only the first beat of the winning input is inspected; it is peeked, not consumed.
    always_comb begin
        port_sel  = USER_W'(data_port(DATA_BASE, DATA_STEP, int'(arb_idx)));
        nohdr_sel = 1'b0;
        if (|(arb_grant & RESP_MASK)) begin
            if (in_data[arb_idx][HDR_FLAG_BIT]) begin
                port_sel = (in_data[arb_idx][SID_LSB +: SID_W] == FC_SID) ?
                           USER_W'(FC_PORT) : USER_W'(CTRL_PORT);
            end else begin
                port_sel  = USER_W'(CTRL_PORT);
                nohdr_sel = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        core_valid = 1'b0;
        core_data  = '0;
        core_last  = 1'b0;
        core_user  = USER_W'(CTRL_PORT);
        in_ready   = '0;
        pkt_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_nxt = ST_PASS;
                end
            end
            ST_PASS: begin
                core_valid            = in_valid[grant_idx_r];
                core_data             = in_data[grant_idx_r];
                core_last             = in_last[grant_idx_r];
                core_user             = port_r;
                in_ready[grant_idx_r] = core_ready;
                if (core_valid && core_ready && core_last) begin
                    pkt_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grant and port are latched once per packet, so they cannot move mid-packet.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state       <= ST_IDLE;
            grant_idx_r <= '0;
            port_r      <= USER_W'(CTRL_PORT);
            rr_ptr      <= IDX_W'(NUM_IN - 1);
            err_nohdr   <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                stat_cnt[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            err_nohdr <= 1'b0;
            if (state == ST_IDLE && arb_valid) begin
                grant_idx_r <= arb_idx;
                port_r      <= port_sel;
                err_nohdr   <= nohdr_sel;
            end
            if (pkt_done) begin
                stat_cnt[grant_idx_r] <= stat_cnt[grant_idx_r] + 16'd1;
                if (!PRIO_MASK[grant_idx_r]) begin
                    rr_ptr <= grant_idx_r;
                end
            end
        end
    end

    if (OUT_REG == 0) begin : g_out_direct
        assign o_tdata    = core_data;
        assign o_tuser    = core_user;
        assign o_tlast    = core_last;
        assign o_tvalid   = core_valid;
        assign core_ready = o_tready;
    end else begin : g_out_reg
        logic [PAY_W-1:0] main_q, skid_q;
        logic             main_v, skid_v;

        assign core_ready = !skid_v;
        assign o_tvalid   = main_v;
        assign {o_tuser, o_tlast, o_tdata} = main_q;

        // Two-entry skid stage: the skid slot absorbs one beat when the sink stalls.
        always_ff @(posedge clk) begin
            if (reset || clear) begin
                main_v <= 1'b0;
                skid_v <= 1'b0;
                main_q <= {USER_W'(CTRL_PORT), 1'b0, CHDR_W'(0)};
                skid_q <= {USER_W'(CTRL_PORT), 1'b0, CHDR_W'(0)};
            end else if (o_tready || !main_v) begin
                if (skid_v) begin
                    main_q <= skid_q;
                    main_v <= 1'b1;
                    skid_v <= 1'b0;
                end else if (core_valid) begin
                    main_q <= {core_user, core_last, core_data};
                    main_v <= 1'b1;
                end else begin
                    main_v <= 1'b0;
                end
            end else if (core_valid && !skid_v) begin
                skid_q <= {core_user, core_last, core_data};
                skid_v <= 1'b1;
            end
        end
    end

endmodule
